// File: rtl/alu_pkg.sv
// Shared encodings for the 4-bit processor ALU path: controller states and op codes.
package alu_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } state_e;

endpackage

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell shared by the serial ALU path; purely combinational.
module full_adder_1bit (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic sum_o,
   output logic cout_o
);

   assign sum_o  = a_i ^ b_i ^ cin_i;
   assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: steps one full_adder_1bit over WIDTH cycles,
// LSB first, with a start/busy/done handshake and registered result plus C/V/Z flags.
module serial_add_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   // Handshake: start is taken only in IDLE; busy covers RUN and DONE;
   // done is a one-cycle pulse marking result/flags valid until the next accepted start.
   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sh_a_q, sh_a_d;
   logic [WIDTH-1:0] sh_b_q, sh_b_d;
   logic             cy_q, cy_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic             fa_sum, fa_cout;
   logic [WIDTH-1:0] result_shift;

   full_adder_1bit u_fa (
      .a_i    (sh_a_q[0]),
      .b_i    (sh_b_q[0]),
      .cin_i  (cy_q),
      .sum_o  (fa_sum),
      .cout_o (fa_cout)
   );

   assign result_shift = {fa_sum, result_q[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         sh_a_q   <= '0;
         sh_b_q   <= '0;
         cy_q     <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sh_a_q   <= sh_a_d;
         sh_b_q   <= sh_b_d;
         cy_q     <= cy_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_a_d   = sh_a_q;
      sh_b_d   = sh_b_q;
      cy_d     = cy_q;
      result_d = result_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
               sh_a_d   = a;
               sh_b_d   = (op_sub == OP_SUB) ? ~b : b;
               cy_d     = (op_sub == OP_SUB);
               cnt_d    = '0;
               result_d = '0;
               carry_d  = 1'b0;
               ovf_d    = 1'b0;
               zero_d   = 1'b0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            result_d = result_shift;
            sh_a_d   = {1'b0, sh_a_q[WIDTH-1:1]};
            sh_b_d   = {1'b0, sh_b_q[WIDTH-1:1]};
            cy_d     = fa_cout;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               // cy_q here is the carry into the MSB.
               carry_d = fa_cout;
               ovf_d   = cy_q ^ fa_cout;
               zero_d  = (result_shift == '0);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign result    = result_q;
   assign carry_out = carry_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=4): scoreboard of expected result/flags,
// latency, pulse-width, busy, hold, ignored-start and mid-run reset checks.
module tb_serial_add_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         op_sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, carry_out, overflow, zero;
   logic [W-1:0] result;

   int errors = 0;
   int checks = 0;

   // Expected entry: {result, C, V, Z}
   logic [W+2:0] exp_q[$];
   logic [W+2:0] last_exp = '0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op_sub    (op_sub),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [W+2:0] model(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] yy;
      logic [W:0]   full;
      logic [W-1:0] r;
      logic         v;
      yy   = op ? ~y : y;
      full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, op};
      r    = full[W-1:0];
      v    = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
      return {r, full[W], v, (r == '0)};
   endfunction

   task automatic issue(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
      @(posedge clk); #1;
      start  = 1'b1;
      op_sub = op;
      a      = x;
      b      = y;
      exp_q.push_back(model(op, x, y));
      @(posedge clk); #1;
      start  = 1'b0;
      // Operands change right after acceptance; they must not matter.
      a      = W'($urandom_range(0, 15));
      b      = W'($urandom_range(0, 15));
      op_sub = 1'($urandom_range(0, 1));
   endtask

   task automatic check_outputs(input string tag, input logic [W+2:0] e);
      check({tag, "_result"}, 32'(result),    32'(e[W+2:3]));
      check({tag, "_carry"},  32'(carry_out), 32'(e[2]));
      check({tag, "_ovf"},    32'(overflow),  32'(e[1]));
      check({tag, "_zero"},   32'(zero),      32'(e[0]));
   endtask

   task automatic wait_done(input string tag, input bit pulse_in_run);
      int  cyc = 0;
      bit  seen = 0;
      logic [W+2:0] e;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            seen  = 1;
            start = 1'b0;
         end else begin
            check({tag, "_busy_run"}, 32'(busy), 32'd1);
            if (pulse_in_run) begin
               start  = 1'b1;
               a      = W'($urandom_range(0, 15));
               b      = W'($urandom_range(0, 15));
               op_sub = 1'($urandom_range(0, 1));
            end
         end
      end
      start = 1'b0;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_timeout: observed=no done expected=done within 20 cycles", tag);
         exp_q.delete();
         return;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(W + 1));
      check({tag, "_busy_done"}, 32'(busy), 32'd1);
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s_queue: observed=empty expected=entry", tag);
         return;
      end
      e = exp_q.pop_front();
      last_exp = e;
      check_outputs(tag, e);
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_busy_idle"}, 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      check_outputs({tag, "_hold"}, e);
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check_outputs("rst", '0);

      issue(1'b0, 4'd3, 4'd5);   wait_done("add_3_5", 1'b0);
      issue(1'b0, 4'd15, 4'd1);  wait_done("add_15_1", 1'b0);
      issue(1'b1, 4'd5, 4'd3);   wait_done("sub_5_3", 1'b0);
      issue(1'b1, 4'd3, 4'd5);   wait_done("sub_3_5", 1'b0);
      issue(1'b1, 4'd7, 4'd8);   wait_done("sub_7_8", 1'b0);
      issue(1'b0, 4'd9, 4'd6);   wait_done("add_9_6", 1'b0);
      issue(1'b1, 4'd8, 4'd1);   wait_done("sub_8_1", 1'b0);

      // start hammered during RUN must be ignored
      issue(1'b0, 4'd6, 4'd7);   wait_done("ign_start", 1'b1);
      repeat (3) @(negedge clk);
      check("ign_no_rerun", 32'(busy), 32'd0);
      check_outputs("ign_hold", last_exp);

      // Reset in the 2nd RUN cycle aborts without done
      issue(1'b0, 4'd2, 4'd3);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check_outputs("abort", '0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("abort_no_done", 32'(done), 32'd0);
      end

      issue(1'b0, 4'd4, 4'd4);   wait_done("post_abort", 1'b0);

      for (int i = 0; i < 6; i++) begin
         issue(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
         wait_done("rand", 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
